// File: rtl/vector_mult_unit.sv
// rtl/vector_mult_unit.sv - two-stage sign-magnitude Q3.12 dot product with saturation
module vector_mult_unit #(
   parameter int N    = 3,
   parameter int W    = 16,
   parameter int FRAC = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [N*W-1:0]   A,
   input  logic [N*W-1:0]   B,
   output logic             out_valid,
   output logic [W-1:0]     RES,
   output logic             sat
);

   // magnitude operand width, full product width, truncated magnitude width
   localparam int MW   = W - 1;
   localparam int FW   = 2 * MW;
   localparam int TW   = FW - FRAC;
   // signed product width (two spare bits) and sum width with headroom for N terms
   localparam int PW   = TW + 2;
   localparam int SW   = PW + $clog2(N) + 1;

   localparam logic signed [SW-1:0] MAX_V = SW'((1 << (W - 1)) - 1);
   localparam logic signed [SW-1:0] MIN_V = -SW'(1 << (W - 1));

   logic signed [PW-1:0] p_d [N];
   logic signed [PW-1:0] p_q [N];
   logic                 v1_q;

   logic signed [SW-1:0] sum_d;
   logic [W-1:0]         res_d, res_q;
   logic                 sat_d, sat_q;
   logic                 ov_q;

   // stage-1 combinational: per-element truncated magnitude product with sign applied
   always_comb begin
      for (int i = 0; i < N; i++) begin
         logic [MW-1:0]        a_mag;
         logic [MW-1:0]        b_mag;
         logic [FW-1:0]        full;
         logic signed [PW-1:0] pos;
         a_mag  = A[i*W +: MW];
         b_mag  = B[i*W +: MW];
         full   = FW'(a_mag) * FW'(b_mag);
         pos    = signed'({2'b00, full[FW-1:FRAC]});
         // a zero magnitude negates to zero, so negative-zero needs no special case
         p_d[i] = (A[i*W + W - 1] ^ B[i*W + W - 1]) ? -pos : pos;
      end
   end

   // stage-2 combinational: sign-extended sum of products and clipping to W bits
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < N; i++) begin
         sum_d = sum_d + {{(SW - PW){p_q[i][PW-1]}}, p_q[i]};
      end
      if (sum_d > MAX_V) begin
         res_d = {1'b0, {(W - 1){1'b1}}};
         sat_d = 1'b1;
      end else if (sum_d < MIN_V) begin
         res_d = {1'b1, {(W - 1){1'b0}}};
         sat_d = 1'b1;
      end else begin
         res_d = sum_d[W-1:0];
         sat_d = 1'b0;
      end
   end

   // pipeline registers: products captured on valid input, result held until next valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            p_q[i] <= '0;
         end
         v1_q  <= 1'b0;
         res_q <= '0;
         sat_q <= 1'b0;
         ov_q  <= 1'b0;
      end else begin
         v1_q <= in_valid;
         ov_q <= v1_q;
         if (in_valid) begin
            for (int i = 0; i < N; i++) begin
               p_q[i] <= p_d[i];
            end
         end
         if (v1_q) begin
            res_q <= res_d;
            sat_q <= sat_d;
         end
      end
   end

   assign out_valid = ov_q;
   assign RES       = res_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_vector_mult_unit.sv
// tb/tb_vector_mult_unit.sv - self-checking bench for vector_mult_unit
module tb_vector_mult_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [47:0] A = '0;
   logic [47:0] B = '0;
   logic        out_valid;
   logic [15:0] RES;
   logic        sat;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          due;
      logic [15:0] res;
      logic        sat;
   } exp_t;

   exp_t        q[$];
   logic [15:0] last_res = '0;
   logic        last_sat = 1'b0;

   vector_mult_unit #(.N(3), .W(16), .FRAC(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .RES       (RES),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [47:0] pk(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
      return {e2, e1, e0};
   endfunction

   // reference dot product in plain integer arithmetic: {sat, RES}
   function automatic logic [16:0] model(input logic [47:0] a, input logic [47:0] b);
      int s;
      s = 0;
      for (int i = 0; i < 3; i++) begin
         int ma;
         int mb;
         int mag;
         ma  = int'(a[16*i +: 15]);
         mb  = int'(b[16*i +: 15]);
         mag = (ma * mb) / 4096;
         if (a[16*i + 15] ^ b[16*i + 15]) s = s - mag;
         else                             s = s + mag;
      end
      if (s > 32767)  return {1'b1, 16'h7FFF};
      if (s < -32768) return {1'b1, 16'h8000};
      return {1'b0, s[15:0]};
   endfunction

   // model timeline: a vector taken at edge k is due after edge k+1; reset drops everything
   always @(posedge clk) begin
      logic [16:0] r;
      cyc++;
      if (!rst_n) begin
         q.delete();
      end else if (in_valid) begin
         exp_t e;
         r     = model(A, B);
         e.due = cyc + 1;
         e.res = r[15:0];
         e.sat = r[16];
         q.push_back(e);
      end
   end

   // compare process: every cycle, outputs against the model timeline
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_out_valid", 32'(out_valid), 32'd0);
         chk("reset_res", 32'(RES), 32'd0);
         chk("reset_sat", 32'(sat), 32'd0);
         last_res = '0;
         last_sat = 1'b0;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         chk("out_valid_pulse", 32'(out_valid), 32'd1);
         chk("res", 32'(RES), 32'(q[0].res));
         chk("sat", 32'(sat), 32'(q[0].sat));
         last_res = q[0].res;
         last_sat = q[0].sat;
         void'(q.pop_front());
      end else begin
         chk("out_valid_idle", 32'(out_valid), 32'd0);
         chk("res_hold", 32'(RES), 32'(last_res));
         chk("sat_hold", 32'(sat), 32'(last_sat));
      end
   end

   // pin the model to a hand-computed value, then present the vector for one cycle
   task automatic send(input logic [47:0] a, input logic [47:0] b, input logic [15:0] er, input logic es);
      logic [16:0] r;
      r = model(a, b);
      chk("model_literal", 32'(r), 32'({es, er}));
      @(negedge clk);
      A        = a;
      B        = b;
      in_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         A        = '0;
         B        = '0;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      idle(2);

      // mixed signs: +0x90 -0x90 -0x90
      send(pk(16'h0300, 16'h0300, 16'h8300), pk(16'h0300, 16'h8300, 16'h0300), 16'hFF70, 1'b0);
      idle(4);
      // positive and negative saturation
      send(pk(16'h7FFF, 16'h7FFF, 16'h7FFF), pk(16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h7FFF, 1'b1);
      idle(3);
      send(pk(16'hFFFF, 16'hFFFF, 16'hFFFF), pk(16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h8000, 1'b1);
      idle(3);
      // zero and negative zero
      send(pk(16'h8000, 16'h0000, 16'h1000), pk(16'h1000, 16'h9000, 16'h0000), 16'h0000, 1'b0);
      idle(3);
      // truncation toward zero of the magnitude
      send(pk(16'h0001, 16'h0000, 16'h0000), pk(16'h0001, 16'h0000, 16'h0000), 16'h0000, 1'b0);
      idle(3);
      send(pk(16'h1000, 16'h0000, 16'h0000), pk(16'h8001, 16'h0000, 16'h0000), 16'hFFFF, 1'b0);
      idle(3);

      // streaming, including exact +32767 and -32768 without saturation
      send(pk(16'h1000, 16'h1000, 16'h1000), pk(16'h1000, 16'h2000, 16'h0000), 16'h3000, 1'b0);
      send(pk(16'h2000, 16'h0000, 16'h0000), pk(16'h9000, 16'h0000, 16'h0000), 16'hE000, 1'b0);
      send(pk(16'h0800, 16'h0800, 16'h0800), pk(16'h0800, 16'h0800, 16'h8800), 16'h0400, 1'b0);
      send(pk(16'h7FFF, 16'h0000, 16'h0000), pk(16'h1000, 16'h0000, 16'h0000), 16'h7FFF, 1'b0);
      send(pk(16'hC000, 16'h0000, 16'h0000), pk(16'h2000, 16'h0000, 16'h0000), 16'h8000, 1'b0);
      idle(5);
      chk("stream_last_held", 32'(RES), 32'h8000);

      // reset one cycle after a valid input discards it
      send(pk(16'h1000, 16'h0000, 16'h0000), pk(16'h1000, 16'h0000, 16'h0000), 16'h1000, 1'b0);
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      idle(4);
      chk("after_reset_res", 32'(RES), 32'h0000);

      // operation resumes after release
      send(pk(16'h0300, 16'h0300, 16'h8300), pk(16'h0300, 16'h8300, 16'h0300), 16'hFF70, 1'b0);
      idle(4);
      chk("resume_res", 32'(RES), 32'hFF70);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
